// File: rtl/data_mem_pkg.sv
// Shared types and widths for the data memory responder slice.
package data_mem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port word array: per-byte write enables, registered read.
module mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [BE_W-1:0]          we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data memory responder with fixed access latency.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [3:0]        cnt;
  req_t              req_q;
  req_t              cur;
  logic              accept;
  logic              access;
  logic              cur_err;
  logic              rsp_valid_q;
  logic              err_q;
  logic              load_q;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready_o = (state == IDLE) & ~rst;
  assign accept      = req_valid_i & req_ready_o;

  // Zero latency accesses straight from the request inputs.
  assign cur = (state == IDLE)
             ? '{we: req_we_i, addr: req_addr_i,
                 wdata: req_wdata_i, be: req_be_i}
             : req_q;

  assign access = (state == IDLE)
                ? (accept && (LATENCY == 0))
                : ((state == WAIT) && (cnt == 4'd0));

  assign cur_err = (|cur.addr[1:0])
                 | (cur.addr[31:2] >= 30'(DEPTH_WORDS));

  mem_array #(
    .DEPTH (DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .en    (access & ~cur_err),
    .we    (cur.we ? cur.be : '0),
    .addr  (cur.addr[AW+1:2]),
    .wdata (cur.wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_q <= cur;
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (access) begin
        state       <= RESP;
        cnt         <= '0;
        rsp_valid_q <= 1'b1;
        err_q       <= cur_err;
        load_q      <= ~cur.we;
      end
    end
  end

  // Read data lives in the array register, which is idle until the next access.
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = (rsp_valid_q & load_q & ~err_q) ? mem_rdata : '0;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in storage (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and access (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port: req_valid_i  in  1  request present.
REQ-007 SHALL have port: req_ready_o  out  1  responder can accept a request.
REQ-008 SHALL have port: req_we_i  in  1  1 = store, 0 = load.
REQ-009 SHALL have port: req_addr_i  in  32  byte address.
REQ-010 SHALL have port: req_wdata_i  in  32  store data.
REQ-011 SHALL have port: req_be_i  in  4  store byte enables; bit n covers wdata[8n+7:8n].
REQ-012 SHALL have port: rsp_valid_o  out  1  response present.
REQ-013 SHALL have port: rsp_ready_i  in  1  initiator accepts response.
REQ-014 SHALL have port: rsp_rdata_o  out  32  load data; 0 for stores and errors.
REQ-015 SHALL have port: rsp_err_o  out  1  misaligned or out-of-range access.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; only one request outstanding.
REQ-017 SHALL drive req_ready_o = 1 only in IDLE; acceptance = req_valid_i & req_ready_o at a rising edge.
REQ-018 SHALL, on acceptance, capture we/addr/wdata/be; go to WAIT with counter = LATENCY-1 if LATENCY > 0, else perform the access at that edge and go to RESP.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; at counter = 0, perform the access at that edge and go to RESP.
REQ-020 SHALL assert rsp_valid_o exactly LATENCY+1 cycles after the acceptance edge.
REQ-021 SHALL flag an error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS; an error suppresses the write and forces rdata = 0.
REQ-022 SHALL, for a store, write only the bytes with be set; be = 0 is legal: no change, no error.
REQ-023 SHALL, for a load, return the full word regardless of be.
REQ-024 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i = 1; at that edge go to IDLE and clear rsp_valid_o.
REQ-025 SHALL NOT accept a request in the same cycle as a response handshake; the earliest next acceptance is the following cycle.
REQ-026 SHALL ignore request inputs outside IDLE.
REQ-027 SHALL ignore rsp_ready_i outside RESP.

Reset
REQ-028 SHALL, while rst = 1, force state IDLE, counter 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0 and req_ready_o 0.
REQ-029 SHALL drive req_ready_o = 1 from the first cycle after rst deasserts.
REQ-030 SHALL NOT reset storage contents.
REQ-031 SHALL discard a pending store when rst asserts in WAIT, with no storage write.

Structure
REQ-032 SHALL take the state encoding (IDLE = 0, WAIT = 1, RESP = 2), the data width (32) and the byte-enable width (4) from the shared package data_mem_pkg.
REQ-033 SHALL instantiate one sub-module mem_array: synchronous single-port word array with per-byte write enables and registered read.

Verification
REQ-034 SHALL cover: LATENCY = 2, store 0xDEADBEEF to addr 0x10 with be = 0xF, then load 0x10 -> rsp_valid 3 cycles after each acceptance, rdata = 0xDEADBEEF, err = 0.
REQ-035 SHALL cover: store 0x000000AA to 0x10 with be = 0x1 over 0xDEADBEEF, then load -> rdata = 0xDEADBEAA.
REQ-036 SHALL cover: load 0x12, then load at 4*DEPTH_WORDS -> err = 1, rdata = 0; a store to 0x12 leaves memory unchanged.
REQ-037 SHALL cover: hold rsp_ready_i = 0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready = 0, a second request is held off and accepted the cycle after the handshake.
REQ-038 SHALL cover: LATENCY = 0 with back-to-back requests and rsp_ready_i = 1 -> response 1 cycle after acceptance, acceptances every 2 cycles.
REQ-039 SHALL cover: assert rst during WAIT of a store to 0x20 -> outputs cleared, 0x20 unchanged, req_ready = 1 the cycle after rst deasserts.
